load_hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle load-use hazard detector in the pipelined CPU.
- Keeps a per-register countdown scoreboard of in-flight loads, so it supports memory stages with a load-to-use latency of LOAD_LAT cycles.
- Drives stall and bubble controls for the PC, the IF/ID register and the ID/EX control mux.
- Adds behaviour the previous detector lacked: register 0 exemption, source-use qualification, flush handling, overwrite by younger writers, and a stall performance counter.

---
 rtl/load_hazard_scoreboard.sv | 90 +++++++++
 tb/tb_load_hazard_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register countdown of in-flight loads.
// Produces stall/bubble controls for PC, IF/ID and the ID/EX control mux,
// and a saturating count of stall cycles.
module load_hazard_scoreboard #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned PERF_W     = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_rs_used_i,
   input  logic                  id_rt_used_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  bubble_o,
   output logic [NUM_REGS-1:0]   pending_o,
   output logic [PERF_W-1:0]     stall_cnt_o
);

   localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] LatInit = CNT_W'(LOAD_LAT);

   logic [CNT_W-1:0]  r_cnt [NUM_REGS];
   logic [PERF_W-1:0] r_stall_cnt;

   logic w_rs_hit;
   logic w_rt_hit;
   logic w_stall;
   logic w_issue;

   // Hazard detection against the registered scoreboard; r0 is never a hazard.
   always_comb begin
      w_rs_hit = id_rs_used_i && (id_rs_i != '0) && (r_cnt[id_rs_i] != '0);
      w_rt_hit = id_rt_used_i && (id_rt_i != '0) && (r_cnt[id_rt_i] != '0);
      w_stall  = id_valid_i && !flush_i && (w_rs_hit || w_rt_hit);
      w_issue  = id_valid_i && !flush_i && !w_stall;
   end

   // Scoreboard update: an issuing writer reloads (load) or clears (ALU) its rd,
   // otherwise non-zero counters count down, including while stalled.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         r_cnt[0] <= '0;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_issue && id_regwrite_i && (id_rd_i == REG_ADDR_W'(r))) begin
               r_cnt[r] <= id_memread_i ? LatInit : '0;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - 1'b1;
            end
         end
      end
   end

   // Saturating stall-cycle performance counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   // Pending vector: one bit per register with a live countdown.
   always_comb begin
      pending_o = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_o[r] = (r_cnt[r] != '0);
      end
   end

   assign stall_o       = w_stall;
   assign pc_write_o    = ~w_stall;
   assign if_id_write_o = ~w_stall;
   assign bubble_o      = w_stall | flush_i;
   assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench for load_hazard_scoreboard: one instance with LOAD_LAT=1,
// one with LOAD_LAT=3 and a 2-bit stall counter to reach saturation.
module tb_load_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, flush;
   logic [4:0]  id_rs, id_rt, id_rd;

   logic        s1_stall, s1_pcw, s1_ifw, s1_bub;
   logic [31:0] s1_pend, s1_scnt;
   logic        s3_stall, s3_pcw, s3_ifw, s3_bub;
   logic [31:0] s3_pend;
   logic [1:0]  s3_scnt;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_hazard_scoreboard #(
      .REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(1), .PERF_W(32)
   ) u_lat1 (
      .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used), .id_rd_i(id_rd),
      .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
      .stall_o(s1_stall), .pc_write_o(s1_pcw), .if_id_write_o(s1_ifw), .bubble_o(s1_bub),
      .pending_o(s1_pend), .stall_cnt_o(s1_scnt)
   );

   load_hazard_scoreboard #(
      .REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(3), .PERF_W(2)
   ) u_lat3 (
      .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used), .id_rd_i(id_rd),
      .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
      .stall_o(s3_stall), .pc_write_o(s3_pcw), .if_id_write_o(s3_ifw), .bubble_o(s3_bub),
      .pending_o(s3_pend), .stall_cnt_o(s3_scnt)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Present an ID-stage instruction and let combinational outputs settle.
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
      id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
      id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      do_reset();

      // Reset state
      check_val("rst_stall",   {31'd0, s3_stall}, 32'd0);
      check_val("rst_pcw",     {31'd0, s3_pcw},   32'd1);
      check_val("rst_ifw",     {31'd0, s3_ifw},   32'd1);
      check_val("rst_bubble",  {31'd0, s3_bub},   32'd0);
      check_val("rst_pending", s3_pend,           32'd0);
      check_val("rst_scnt",    s1_scnt,           32'd0);

      // 1: LOAD_LAT=1 single bubble
      drive(1, 5'd1, 5'd2, 0, 0, 5'd5, 1, 1, 0);
      check_val("t1_load_nostall", {31'd0, s1_stall}, 32'd0);
      tick();
      drive(1, 5'd5, 5'd0, 1, 0, 5'd10, 1, 0, 0);
      check_val("t1_pend5",  {31'd0, s1_pend[5]}, 32'd1);
      check_val("t1_stall",  {31'd0, s1_stall},   32'd1);
      check_val("t1_pcw",    {31'd0, s1_pcw},     32'd0);
      check_val("t1_bubble", {31'd0, s1_bub},     32'd1);
      tick();
      check_val("t1_released", {31'd0, s1_stall}, 32'd0);
      check_val("t1_scnt",     s1_scnt,           32'd1);
      tick();
      check_val("t1_scnt_hold", s1_scnt, 32'd1);

      // 2: LOAD_LAT=3, three-cycle stall, then saturation of 2-bit counter
      do_reset();
      drive(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0);
      tick();
      drive(1, 5'd0, 5'd8, 0, 1, 5'd11, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("t2_stall%0d", i), {31'd0, s3_stall}, 32'd1);
         check_val($sformatf("t2_pcw%0d", i),   {31'd0, s3_pcw},   32'd0);
         check_val($sformatf("t2_ifw%0d", i),   {31'd0, s3_ifw},   32'd0);
         check_val($sformatf("t2_pend%0d", i),  {31'd0, s3_pend[8]}, 32'd1);
         tick();
      end
      check_val("t2_release", {31'd0, s3_stall},   32'd0);
      check_val("t2_pend8",   {31'd0, s3_pend[8]}, 32'd0);
      check_val("t2_scnt",    {30'd0, s3_scnt},    32'd3);
      tick();
      drive(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0);
      tick();
      drive(1, 5'd8, 5'd0, 1, 0, 5'd11, 1, 0, 0);
      check_val("t2_restall", {31'd0, s3_stall}, 32'd1);
      tick();
      check_val("t2_scnt_sat", {30'd0, s3_scnt}, 32'd3);
      idle();

      // 3: r0 exemption and source-use qualification
      do_reset();
      drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0);
      tick();
      check_val("t3_pend_r0", s3_pend, 32'd0);
      drive(1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 0, 0);
      check_val("t3_r0_nostall", {31'd0, s3_stall}, 32'd0);
      drive(1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0);
      tick();
      drive(1, 5'd4, 5'd1, 0, 1, 5'd13, 1, 0, 0);
      check_val("t3_pend4",       {31'd0, s3_pend[4]}, 32'd1);
      check_val("t3_unused_nost", {31'd0, s3_stall},   32'd0);
      tick();

      // 4: younger ALU write supersedes a pending load
      do_reset();
      drive(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0);
      tick();
      drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
      check_val("t4_alu_nostall", {31'd0, s3_stall}, 32'd0);
      tick();
      drive(1, 5'd7, 5'd0, 1, 0, 5'd14, 1, 0, 0);
      check_val("t4_pend7",  {31'd0, s3_pend[7]}, 32'd0);
      check_val("t4_reader", {31'd0, s3_stall},   32'd0);
      tick();

      // 5: flush suppresses stall and issue, counters keep counting down
      do_reset();
      drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0);
      tick();
      drive(1, 5'd9, 5'd0, 1, 0, 5'd12, 1, 1, 1);
      check_val("t5_stall",  {31'd0, s3_stall}, 32'd0);
      check_val("t5_bubble", {31'd0, s3_bub},   32'd1);
      check_val("t5_pcw",    {31'd0, s3_pcw},   32'd1);
      tick();
      check_val("t5_noissue", {31'd0, s3_pend[12]}, 32'd0);
      check_val("t5_pend9",   {31'd0, s3_pend[9]},  32'd1);
      drive(1, 5'd9, 5'd0, 1, 0, 5'd12, 1, 0, 0);
      check_val("t5_stall_a", {31'd0, s3_stall}, 32'd1);
      tick();
      check_val("t5_stall_b", {31'd0, s3_stall}, 32'd1);
      tick();
      check_val("t5_done",    {31'd0, s3_stall}, 32'd0);
      check_val("t5_scnt",    {30'd0, s3_scnt},  32'd2);
      tick();

      // 6: asynchronous reset during a stall
      do_reset();
      drive(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0);
      tick();
      drive(1, 5'd8, 5'd0, 1, 0, 5'd15, 1, 0, 0);
      check_val("t6_stall_pre", {31'd0, s3_stall}, 32'd1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_async_stall", {31'd0, s3_stall}, 32'd0);
      check_val("t6_async_pcw",   {31'd0, s3_pcw},   32'd1);
      check_val("t6_async_pend",  s3_pend,           32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check_val("t6_post_stall", {31'd0, s3_stall}, 32'd0);
      check_val("t6_post_pend",  s3_pend,           32'd0);
      check_val("t6_post_scnt",  {30'd0, s3_scnt},  32'd0);
      check_val("t6_post_bub",   {31'd0, s3_bub},   32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
